fifo_memoria: RTL and testbench

- Synchronous FIFO built on a parametrised dual-port register memory; replaces the bare addressed memory wherever the datapath needs ordered buffering.
- Owns the write/read pointers, the occupancy counter and the status flags, so producers and consumers no longer drive addresses.
- Sits between a producer issuing push requests and a consumer issuing pop requests, both in the single clk domain.

---
 rtl/fifo_memoria_pkg.sv | 21 ++
 rtl/memoria_dp.sv | 43 ++++
 rtl/fifo_memoria.sv | 114 +++++++++++
 tb/tb_fifo_memoria.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_memoria_pkg.sv
// Shared sizing for the FIFO and its storage array: default parameters,
// depth derivation (MEM_LENGTH = 1 << ADDR_WIDTH) and occupancy counter width.
// Latency / backpressure: not applicable (declarations only).
package fifo_memoria_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_BUS_SIZE   = 4;
    localparam int DEF_AF_THRESH  = 14;
    localparam int DEF_AE_THRESH  = 2;

    // Number of words addressable by a pointer of the given width.
    function automatic int mem_length(input int addr_width);
        return 1 << addr_width;
    endfunction

    // One extra bit so a completely full FIFO (MEM_LENGTH) is representable.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/memoria_dp.sv
// Dual-port register array: one write port, one read port with a registered output.
// Latency: write visible to a read on the next edge; read data valid 1 cycle after read.
// Backpressure: none; the owner decides when write/read may fire.
// Ports: clk, reset_L (clears only the output register), write/address_w/data_in,
//        read/address_r/data_out.
module memoria_dp
    import fifo_memoria_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BUS_SIZE   = DEF_BUS_SIZE
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address_w,
    input  logic [BUS_SIZE-1:0]   data_in,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] address_r,
    output logic [BUS_SIZE-1:0]   data_out
);

    localparam int MEM_LENGTH = mem_length(ADDR_WIDTH);

    // Storage is deliberately not reset: contents are meaningless until written.
    logic [BUS_SIZE-1:0] mem [MEM_LENGTH];

    always_ff @(posedge clk) begin
        if (write) begin
            mem[address_w] <= data_in;
        end
    end

    // When the same address is written and read on one edge the read returns
    // the old word; the FIFO relies on this for push+pop while full.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out <= '0;
        end else if (read) begin
            data_out <= mem[address_r];
        end
    end

endmodule

// File: rtl/fifo_memoria.sv
// Synchronous FIFO over memoria_dp: owns pointers, occupancy count and status flags.
// Latency: popped word appears on data_out one cycle after the accepted pop (data_out_valid).
// Backpressure: push at full (without pop) and pop at empty are dropped silently.
// Ports: clk, reset_L (async, active-low), push/data_in, pop, data_out/data_out_valid,
//        full, empty, almost_full, almost_empty, count.
// Optional: define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_memoria
    import fifo_memoria_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BUS_SIZE   = DEF_BUS_SIZE,
    parameter int AF_THRESH  = DEF_AF_THRESH,
    parameter int AE_THRESH  = DEF_AE_THRESH
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    input  logic [BUS_SIZE-1:0]   data_in,
    output logic [BUS_SIZE-1:0]   data_out,
    output logic                  data_out_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [ADDR_WIDTH:0]   count
);

    localparam int MEM_LENGTH = mem_length(ADDR_WIDTH);
    localparam int CW         = count_width(ADDR_WIDTH);

    localparam logic [CW-1:0] FULL_C = CW'(MEM_LENGTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

    if (AF_THRESH > MEM_LENGTH || AE_THRESH >= AF_THRESH) begin : g_param_err
        $error("fifo_memoria: need AF_THRESH <= depth and AE_THRESH < AF_THRESH");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // Flags decode the registered count, so they move the cycle after the change.
    assign full         = (count == FULL_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A push while full is still legal when a pop frees the slot on the same edge.
    // No bypass at empty: the pop is rejected even if a push arrives alongside.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            data_out_valid <= 1'b0;
        end else begin
            // Pointers wrap naturally at MEM_LENGTH (power-of-two depth).
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            data_out_valid <= pop_ok;
        end
    end

    memoria_dp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BUS_SIZE   (BUS_SIZE)
    ) u_mem (
        .clk       (clk),
        .reset_L   (reset_L),
        .write     (push_ok),
        .address_w (wr_ptr),
        .data_in   (data_in),
        .read      (pop_ok),
        .address_r (rd_ptr),
        .data_out  (data_out)
    );

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error indicators for requests that were dropped.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push & full & ~pop) begin
                overflow <= 1'b1;
            end
            if (pop & empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_memoria.sv
module tb_fifo_memoria;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       push;
    logic       pop;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       data_out_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    fifo_memoria dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .push           (push),
        .pop            (pop),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .full           (full),
        .empty          (empty),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow       (overflow),
        .underflow      (underflow),
`endif
        .count          (count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [3:0] mq[$];     // reference FIFO contents
    logic [3:0] exp_q[$];  // scoreboard: words expected on data_out
    logic [3:0] last_dout;

    typedef struct {
        logic       push;
        logic       pop;
        logic [3:0] din;
        int         exp_count;
        logic       exp_valid;
    } vec_t;

    vec_t vt[34];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status(input string tag, input int ec);
        chk({tag, " count"},        32'(count),        32'(ec));
        chk({tag, " full"},         32'(full),         32'(ec == 16));
        chk({tag, " empty"},        32'(empty),        32'(ec == 0));
        chk({tag, " almost_full"},  32'(almost_full),  32'(ec >= 14));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(ec <= 2));
    endtask

    // One clock of stimulus. exp_cnt / exp_vld < 0 means: take expectation from the reference model.
    task automatic step(input string tag, input logic p, input logic q, input logic [3:0] d,
                        input int exp_cnt, input int exp_vld);
        logic       pok;
        logic       qok;
        logic       ev;
        logic [3:0] ed;
        int         ec;
        push    = p;
        pop     = q;
        data_in = d;
        pok = p && ((mq.size() != 16) || q);
        qok = q && (mq.size() != 0);
        if (qok) exp_q.push_back(mq.pop_front());
        if (pok) mq.push_back(d);
        ec = (exp_cnt < 0) ? mq.size() : exp_cnt;
        ev = (exp_vld < 0) ? qok : (exp_vld != 0);
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        check_status(tag, ec);
        chk({tag, " data_out_valid"}, 32'(data_out_valid), 32'(ev));
        if (ev) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL %s scoreboard: valid expected but no word queued", tag);
            end else begin
                ed = exp_q.pop_front();
                chk({tag, " data_out"}, 32'(data_out), 32'(ed));
                last_dout = ed;
            end
        end else begin
            chk({tag, " data_out hold"}, 32'(data_out), 32'(last_dout));
        end
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        mq.delete();
        exp_q.delete();
        last_dout = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_status("reset", 0);
        chk("reset data_out", 32'(data_out), 32'h0);
        chk("reset data_out_valid", 32'(data_out_valid), 32'h0);
        reset_L = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = 4'h0;
        last_dout = 4'h0;

        // Table: fill 0..F, overfill, drain 16, pop at empty.
        for (int i = 0; i < 16; i++) vt[i] = '{1'b1, 1'b0, 4'(i), i + 1, 1'b0};
        vt[16] = '{1'b1, 1'b0, 4'h5, 16, 1'b0};
        for (int i = 0; i < 16; i++) vt[17 + i] = '{1'b0, 1'b1, 4'h0, 15 - i, 1'b1};
        vt[33] = '{1'b0, 1'b1, 4'h0, 0, 1'b0};

        do_reset();

        for (int i = 0; i < 34; i++) begin
            step($sformatf("vec%0d", i), vt[i].push, vt[i].pop, vt[i].din,
                 vt[i].exp_count, int'(vt[i].exp_valid));
        end
        chk("drain end data_out", 32'(data_out), 32'hF);

        // Full with simultaneous push 0xA and pop: oldest word out, count unchanged.
        for (int i = 0; i < 16; i++) step("refill", 1'b1, 1'b0, 4'(i), i + 1, 0);
        step("full push+pop", 1'b1, 1'b1, 4'hA, 16, 1);
        for (int i = 0; i < 16; i++) step("drain after full push+pop", 1'b0, 1'b1, 4'h0, 15 - i, 1);

        // Empty with simultaneous push 0x7 and pop: write only, no bypass.
        step("empty push+pop", 1'b1, 1'b1, 4'h7, 1, 0);
        step("pop after empty push+pop", 1'b0, 1'b1, 4'h0, 0, 1);
        chk("empty push+pop word", 32'(data_out), 32'h7);

        // Steady stream at occupancy 3 across several pointer wraps.
        for (int i = 0; i < 3; i++) begin
            r = 4'($urandom_range(15));
            step("prime", 1'b1, 1'b0, r, i + 1, 0);
        end
        for (int i = 0; i < 40; i++) begin
            r = 4'($urandom_range(15));
            step("stream", 1'b1, 1'b1, r, 3, 1);
        end

        // Mid-stream asynchronous reset, checked before the next clock edge.
        #2;
        reset_L = 1'b0;
        #1;
        chk("async reset count", 32'(count), 32'h0);
        chk("async reset empty", 32'(empty), 32'h1);
        chk("async reset data_out_valid", 32'(data_out_valid), 32'h0);
        chk("async reset data_out", 32'(data_out), 32'h0);
        mq.delete();
        exp_q.delete();
        last_dout = 4'h0;
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        step("post reset push", 1'b1, 1'b0, 4'h9, 1, 0);
        step("post reset pop", 1'b0, 1'b1, 4'h0, 0, 1);
        chk("post reset word", 32'(data_out), 32'h9);

`ifdef FIFO_ERR_FLAGS_EN
        do_reset();
        chk("err reset overflow", 32'(overflow), 32'h0);
        chk("err reset underflow", 32'(underflow), 32'h0);
        step("underflow pop", 1'b0, 1'b1, 4'h0, 0, 0);
        chk("underflow set", 32'(underflow), 32'h1);
        chk("overflow clear", 32'(overflow), 32'h0);
        for (int i = 0; i < 16; i++) step("err fill", 1'b1, 1'b0, 4'(i), i + 1, 0);
        chk("underflow sticky", 32'(underflow), 32'h1);
        chk("overflow before", 32'(overflow), 32'h0);
        step("overflow push", 1'b1, 1'b0, 4'h3, 16, 0);
        chk("overflow set", 32'(overflow), 32'h1);
        do_reset();
        chk("overflow cleared by reset", 32'(overflow), 32'h0);
        chk("underflow cleared by reset", 32'(underflow), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
